// File: rtl/mem_dump_reader_if.sv
// Command, memory-stage fetch and output-stream signals of mem_dump_reader.
// The slave modport is the reader's view; master is the surrounding system.
interface mem_dump_reader_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [16:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        interlock;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_result;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        done;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, fetch_result, dout_ready,
        input  cmd_ready, interlock, fetch_addr, dout, dout_valid, done
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, fetch_result, dout_ready,
        output cmd_ready, interlock, fetch_addr, dout, dout_valid, done
    );
endinterface

// File: rtl/mem_dump_reader.sv
// Streams a range of data-BRAM words through the memory stage while stalling the core,
// buffering returned words in a small FIFO for a valid/ready consumer.
module mem_dump_reader #(
    parameter int unsigned FETCH_LAT  = 3,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    mem_dump_reader_if.slave bus_io
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW:0]   DepthCmp = (CntW + 1)'(FIFO_DEPTH);
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e               state_q;
    logic [16:0]          addr_q;
    logic [15:0]          remaining_q;
    logic [FETCH_LAT-1:0] inflight_q;
    logic                 interlock_q;
    logic                 done_q;
    logic                 cmd_ready_q;

    logic [31:0]          mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic [CntW-1:0]      count_q;

    logic [CntW-1:0]      inflight_cnt;
    logic [CntW:0]        credit_sum;
    logic [FETCH_LAT-1:0] inflight_d;
    logic                 issue;
    logic                 capture;
    logic                 pop;
    logic                 handshake;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < int'(FETCH_LAT); i++) begin
            inflight_cnt = inflight_cnt + CntW'(inflight_q[i]);
        end
        // Words already in flight hold a FIFO slot so a capture can never overflow it.
        credit_sum = {1'b0, count_q} + {1'b0, inflight_cnt};
        issue      = (state_q == StIssue) && (credit_sum < DepthCmp);
        inflight_d = (inflight_q << 1) | FETCH_LAT'(issue);
        capture    = inflight_q[FETCH_LAT-1];
        pop        = (count_q != '0) && bus_io.dout_ready;
        handshake  = bus_io.cmd_valid && cmd_ready_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= '0;
            interlock_q <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            inflight_q <= inflight_d;
            done_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (handshake) begin
                        addr_q      <= bus_io.cmd_addr;
                        remaining_q <= bus_io.cmd_len;
                        if (bus_io.cmd_len != '0) begin
                            state_q     <= StIssue;
                            interlock_q <= 1'b1;
                            cmd_ready_q <= 1'b0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (issue) begin
                        addr_q      <= addr_q + 17'd1;
                        remaining_q <= remaining_q - 16'd1;
                        if (remaining_q == 16'd1) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (inflight_d == '0) begin
                        state_q     <= StIdle;
                        interlock_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        done_q      <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            assert (!(capture && !pop && count_q == DepthCnt))
                else $error("mem_dump_reader: output FIFO overflow");
            if (capture) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (capture && !pop)      count_q <= count_q + CntW'(1);
            else if (pop && !capture) count_q <= count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (capture) mem_q[wr_ptr_q] <= bus_io.fetch_result;
    end

    assign bus_io.cmd_ready  = cmd_ready_q;
    assign bus_io.interlock  = interlock_q;
    assign bus_io.fetch_addr = {15'b0, addr_q};
    assign bus_io.done       = done_q;
    assign bus_io.dout_valid = (count_q != '0);
    assign bus_io.dout       = mem_q[rd_ptr_q];
endmodule
